priv_1_12_trap_redirect_ctrl: RTL and testbench

Parametrised trap/return redirect controller for the privilege unit. It captures a trap (exception or interrupt), `mret` or `sret` and computes the target PC from `mtvec`/`stvec` (direct or vectored) or `mepc`/`sepc`. It then flushes the pipeline for a programmable number of cycles and presents the target to fetch over a valid/ready handshake. It sits between the privilege CSR block and the fetch/hazard unit. It adds supervisor delegation, a bounded vector table, event latching and backpressure.

---
 rtl/priv_1_12_trap_redirect_ctrl.sv | 130 +++++++++++++
 tb/tb_priv_1_12_trap_redirect_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/priv_1_12_trap_redirect_ctrl.sv
// Trap / return redirect controller.
// Captures a trap, mret or sret, freezes the computed target PC, squashes the
// pipeline for FLUSH_CYCLES cycles and then offers the target to fetch.
//
// Handshake: redirect_valid/redirect_pc form a valid/ready source. Once
// redirect_valid rises it stays high and redirect_pc stays constant until a
// cycle in which redirect_valid && redirect_ready; the transfer happens at the
// end of that cycle and the controller is idle in the following cycle.
module priv_1_12_trap_redirect_ctrl #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned NUM_VEC_CAUSES = 16,
    parameter int unsigned FLUSH_CYCLES   = 2,
    parameter bit          SUPERVISOR     = 1'b1
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            trap,
    input  logic            trap_is_intr,
    input  logic [XLEN-2:0] trap_cause,
    input  logic            trap_to_s,
    input  logic            mret,
    input  logic            sret,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] stvec,
    input  logic [XLEN-1:0] mepc,
    input  logic [XLEN-1:0] sepc,
    input  logic            redirect_ready,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic            busy,
    output logic            overrun,
    output logic [1:0]      state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FLUSH    = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    // A zero-cycle flush still needs a one-bit counter to keep widths legal.
    localparam int unsigned CW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [CW-1:0]   CNT_LOAD  = CW'(FLUSH_CYCLES);
    localparam logic [XLEN:0]   VEC_LIMIT = (XLEN + 1)'(NUM_VEC_CAUSES);
    localparam logic [XLEN-1:0] TVEC_MASK = {{(XLEN - 2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] EPC_MASK  = {{(XLEN - 1){1'b1}}, 1'b0};

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] tvec;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] target;
    logic            vec_hit;
    logic            sret_evt;
    logic            evt;

    // sret only counts as an event when the S-mode path exists.
    assign sret_evt = SUPERVISOR && sret;
    assign evt      = trap || mret || sret_evt;

    // Target PC for the highest-priority event presented this cycle.
    always_comb begin
        tvec    = (SUPERVISOR && trap_to_s) ? stvec : mtvec;
        base    = tvec & TVEC_MASK;
        vec_hit = (tvec[1:0] == 2'b01) && trap_is_intr
                  && ({1'b0, 1'b0, trap_cause} < VEC_LIMIT);
        if (trap) begin
            target = vec_hit ? (base + XLEN'({trap_cause, 2'b00})) : base;
        end else if (mret) begin
            target = mepc & EPC_MASK;
        end else begin
            target = sepc & EPC_MASK;
        end
    end

    // Next-state, counter and latched-target logic.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pc_next    = redirect_pc;
        unique case (state)
            S_IDLE: begin
                if (evt) begin
                    pc_next    = target;
                    cnt_next   = CNT_LOAD;
                    state_next = (FLUSH_CYCLES == 0) ? S_REDIRECT : S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (cnt <= CW'(1)) begin
                    state_next = S_REDIRECT;
                end
                if (cnt != '0) begin
                    cnt_next = cnt - CW'(1);
                end
            end
            S_REDIRECT: begin
                if (redirect_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State, counter, frozen target and overrun pulse registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= S_IDLE;
            cnt         <= '0;
            redirect_pc <= '0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            redirect_pc <= pc_next;
            overrun     <= (state != S_IDLE) && evt;
        end
    end

    assign redirect_valid = (state == S_REDIRECT);
    assign flush          = (state != S_IDLE);
    assign busy           = (state != S_IDLE);
    assign state_dbg      = state;

endmodule

// File: tb/tb_priv_1_12_trap_redirect_ctrl.sv
// Bench for the trap redirect controller: a default-parameter instance checked
// against a cycle-level reference model and an expected-PC queue, plus a
// second instance without S-mode and with a zero-cycle flush.
module tb_priv_1_12_trap_redirect_ctrl;

    localparam int XLEN = 32;
    localparam int NVC  = 16;
    localparam int FC   = 2;

    logic CLK  = 1'b0;
    logic nRST = 1'b1;

    // Main instance signals
    logic            trap, trap_is_intr, trap_to_s, mret, sret, redirect_ready;
    logic [XLEN-2:0] trap_cause;
    logic [XLEN-1:0] mtvec, stvec, mepc, sepc;
    logic            redirect_valid, flush, busy, overrun;
    logic [XLEN-1:0] redirect_pc;
    logic [1:0]      state_dbg;

    // Second instance signals (SUPERVISOR=0, FLUSH_CYCLES=0)
    logic            b_trap, b_intr, b_to_s, b_mret, b_sret, b_ready;
    logic [XLEN-2:0] b_cause;
    logic [XLEN-1:0] b_mtvec, b_stvec, b_mepc, b_sepc;
    logic            b_valid, b_flush, b_busy, b_overrun;
    logic [XLEN-1:0] b_pc, b_exp;
    logic [1:0]      b_state_dbg;

    // Scoreboard and model state
    logic [XLEN-1:0] exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    bit   chk_en   = 1'b0;
    bit   m_pending = 1'b0;
    bit   m_ovr     = 1'b0;
    int   m_start   = 0;
    int   cyc       = 0;
    bit   ev_prev   = 1'b0;
    bit   rdy_prev  = 1'b0;
    logic [XLEN-1:0] cand_pc = '0;
    bit   exp_busy  = 1'b0;
    bit   exp_valid = 1'b0;
    bit   exp_ovr   = 1'b0;

    priv_1_12_trap_redirect_ctrl #(
        .XLEN(XLEN), .NUM_VEC_CAUSES(NVC), .FLUSH_CYCLES(FC), .SUPERVISOR(1'b1)
    ) u_dut (
        .CLK(CLK), .nRST(nRST), .trap(trap), .trap_is_intr(trap_is_intr),
        .trap_cause(trap_cause), .trap_to_s(trap_to_s), .mret(mret), .sret(sret),
        .mtvec(mtvec), .stvec(stvec), .mepc(mepc), .sepc(sepc),
        .redirect_ready(redirect_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .flush(flush), .busy(busy), .overrun(overrun),
        .state_dbg(state_dbg)
    );

    priv_1_12_trap_redirect_ctrl #(
        .XLEN(XLEN), .NUM_VEC_CAUSES(NVC), .FLUSH_CYCLES(0), .SUPERVISOR(1'b0)
    ) u_dut_b (
        .CLK(CLK), .nRST(nRST), .trap(b_trap), .trap_is_intr(b_intr),
        .trap_cause(b_cause), .trap_to_s(b_to_s), .mret(b_mret), .sret(b_sret),
        .mtvec(b_mtvec), .stvec(b_stvec), .mepc(b_mepc), .sepc(b_sepc),
        .redirect_ready(b_ready), .redirect_valid(b_valid),
        .redirect_pc(b_pc), .flush(b_flush), .busy(b_busy), .overrun(b_overrun),
        .state_dbg(b_state_dbg)
    );

    // Clock
    always #5 CLK = ~CLK;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h required 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference target: written straight from the trap/return rules.
    function automatic logic [XLEN-1:0] ref_pc(input bit sup, input logic tr, input logic intr,
                                               input logic [XLEN-2:0] cause, input logic to_s,
                                               input logic mr, input logic [XLEN-1:0] mt,
                                               input logic [XLEN-1:0] st, input logic [XLEN-1:0] me,
                                               input logic [XLEN-1:0] se);
        logic [XLEN-1:0] tv, base, off;
        if (tr) begin
            tv   = (sup && to_s) ? st : mt;
            base = tv - (tv % 4);
            off  = XLEN'(cause) * 4;
            if ((tv % 4 == 1) && intr && (cause < NVC)) return base + off;
            return base;
        end
        if (mr) return me - (me % 2);
        return se - (se % 2);
    endfunction

    // One clock cycle: advance the model over the edge just passed, then drive
    // the inputs for the next edge.
    task automatic step(input logic tr, input logic intr, input logic [XLEN-2:0] cause,
                        input logic to_s, input logic mr, input logic sr, input logic rdy,
                        input logic [XLEN-1:0] mt, input logic [XLEN-1:0] st,
                        input logic [XLEN-1:0] me, input logic [XLEN-1:0] se);
        bit p_busy, p_valid;
        @(posedge CLK);
        #1;
        cyc++;
        p_busy  = m_pending;
        p_valid = m_pending && ((cyc - 1) >= (m_start + FC));
        m_ovr   = 1'b0;
        if (p_valid && rdy_prev) m_pending = 1'b0;
        if (ev_prev) begin
            if (p_busy) begin
                m_ovr = 1'b1;
            end else begin
                m_pending = 1'b1;
                m_start   = cyc;
                exp_q.push_back(cand_pc);
            end
        end
        exp_busy  = m_pending;
        exp_valid = m_pending && (cyc >= (m_start + FC));
        exp_ovr   = m_ovr;
        trap = tr; trap_is_intr = intr; trap_cause = cause; trap_to_s = to_s;
        mret = mr; sret = sr; redirect_ready = rdy;
        mtvec = mt; stvec = st; mepc = me; sepc = se;
        ev_prev  = tr || mr || sr;
        rdy_prev = rdy;
        cand_pc  = ref_pc(1'b1, tr, intr, cause, to_s, mr, mt, st, me, se);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, rdy, mtvec, stvec, mepc, sepc);
    endtask

    task automatic zero_inputs();
        trap = 0; trap_is_intr = 0; trap_cause = '0; trap_to_s = 0; mret = 0; sret = 0;
        redirect_ready = 0; mtvec = '0; stvec = '0; mepc = '0; sepc = '0;
        b_trap = 0; b_intr = 0; b_cause = '0; b_to_s = 0; b_mret = 0; b_sret = 0;
        b_ready = 0; b_mtvec = '0; b_stvec = '0; b_mepc = '0; b_sepc = '0;
    endtask

    // Asynchronous reset between clock edges, checked before any edge.
    task automatic reset_mid();
        #2;
        nRST = 1'b0;
        zero_inputs();
        #1;
        chk("rst_valid", redirect_valid, 0);
        chk("rst_pc", redirect_pc, 0);
        chk("rst_flush", flush, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        m_pending = 0; m_ovr = 0; ev_prev = 0; rdy_prev = 0;
        exp_busy = 0; exp_valid = 0; exp_ovr = 0;
        exp_q.delete();
        @(negedge CLK);
        #2;
        nRST = 1'b1;
    endtask

    // Monitor: compare status against the model and pop the expected PC on
    // each accepted redirect.
    always @(negedge CLK) begin
        if (nRST && chk_en) begin
            chk("busy", busy, exp_busy);
            chk("flush", flush, exp_busy);
            chk("redirect_valid", redirect_valid, exp_valid);
            chk("overrun", overrun, exp_ovr);
            if (redirect_valid) begin
                chk("pc_expected", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    chk("redirect_pc", redirect_pc, exp_q[0]);
                    if (redirect_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        zero_inputs();
        #1 nRST = 1'b0;
        #10;
        chk("init_valid", redirect_valid, 0);
        chk("init_pc", redirect_pc, 0);
        chk("init_flush", flush, 0);
        chk("init_busy", busy, 0);
        chk("init_overrun", overrun, 0);
        chk("init_b_valid", b_valid, 0);
        nRST = 1'b1;
        chk_en = 1'b1;

        // Vectored interrupt
        step(1, 1, 31'd7, 0, 0, 0, 1, 32'h8000_0001, 32'h0000_4000, '0, '0);
        idle(5, 1);
        // Direct and bounded vector cases
        step(1, 0, 31'd7, 0, 0, 0, 1, 32'h8000_0001, 32'h0000_4000, '0, '0);
        idle(5, 1);
        step(1, 1, 31'd20, 0, 0, 0, 1, 32'h8000_0001, 32'h0000_4000, '0, '0);
        idle(5, 1);
        step(1, 1, 31'd7, 0, 0, 0, 1, 32'h8000_0003, 32'h0000_4000, '0, '0);
        idle(5, 1);
        // Delegation and returns
        step(1, 0, 31'd2, 1, 0, 0, 1, 32'h8000_0001, 32'h0000_4000, '0, '0);
        idle(5, 1);
        step(0, 0, '0, 0, 1, 0, 1, 32'h8000_0001, 32'h0000_4000, 32'h1235, '0);
        idle(5, 1);
        step(0, 0, '0, 0, 0, 1, 1, 32'h8000_0001, 32'h0000_4000, 32'h1235, 32'h2000);
        idle(5, 1);
        // Simultaneous trap and mret
        step(1, 0, 31'd3, 0, 1, 0, 1, 32'h0000_0100, 32'h0000_4000, 32'h1235, 32'h2000);
        idle(5, 1);
        // Backpressure with a dropped mret and changing mtvec
        step(1, 0, 31'd1, 0, 0, 0, 0, 32'h0000_0100, 32'h0000_4000, 32'h1235, 32'h2000);
        idle(2, 0);
        step(0, 0, '0, 0, 1, 0, 0, 32'h0000_7770, 32'h0000_4000, 32'h1235, 32'h2000);
        step(0, 0, '0, 0, 0, 0, 0, 32'h0000_5551, 32'h0000_4000, 32'h1235, 32'h2000);
        step(0, 0, '0, 0, 0, 0, 0, 32'h0000_5551, 32'h0000_4000, 32'h1235, 32'h2000);
        idle(4, 1);
        // Reset during FLUSH, then a normal trap
        step(1, 1, 31'd2, 0, 0, 0, 1, 32'h8000_0001, 32'h0000_4000, '0, '0);
        step(0, 0, '0, 0, 0, 0, 1, 32'h8000_0001, 32'h0000_4000, '0, '0);
        reset_mid();
        step(1, 1, 31'd5, 0, 0, 0, 1, 32'h8000_0001, 32'h0000_4000, '0, '0);
        idle(5, 1);

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            logic [XLEN-2:0] cz;
            cz = ($urandom_range(0, 3) == 0) ? XLEN'($urandom) : XLEN'($urandom_range(0, 24));
            step(($urandom_range(0, 3) == 0), $urandom_range(0, 1), cz, $urandom_range(0, 1),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 9) < 7), $urandom, $urandom, $urandom, $urandom);
        end
        idle(8, 1);
        @(negedge CLK);
        #1;
        chk("queue_drained", exp_q.size(), 0);

        // No S-mode: sret alone is ignored
        @(posedge CLK); #1;
        b_sret = 1; b_sepc = 32'h2000;
        @(posedge CLK); #1;
        b_sret = 0;
        @(negedge CLK);
        chk("nosup_sret_busy", b_busy, 0);
        chk("nosup_sret_valid", b_valid, 0);
        @(negedge CLK);
        chk("nosup_sret_overrun", b_overrun, 0);
        // No S-mode, zero flush: delegation ignored, valid the cycle after capture
        @(posedge CLK); #1;
        b_trap = 1; b_intr = 1; b_cause = 31'd3; b_to_s = 1;
        b_mtvec = 32'h0020_0001; b_stvec = 32'h0000_4000; b_ready = 0;
        b_exp = ref_pc(1'b0, 1, 1, 31'd3, 1, 0, b_mtvec, b_stvec, b_mepc, b_sepc);
        @(posedge CLK); #1;
        b_trap = 0;
        @(negedge CLK);
        chk("zf_valid", b_valid, 1);
        chk("zf_busy", b_busy, 1);
        chk("zf_flush", b_flush, 1);
        chk("zf_pc", b_pc, b_exp);
        @(posedge CLK); #1;
        b_ready = 1;
        @(negedge CLK);
        chk("zf_valid_held", b_valid, 1);
        chk("zf_pc_held", b_pc, b_exp);
        @(posedge CLK); #1;
        b_ready = 0;
        @(negedge CLK);
        chk("zf_valid_done", b_valid, 0);
        chk("zf_busy_done", b_busy, 0);
        chk("zf_flush_done", b_flush, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
